// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MIPS pipeline hazard scheduler.
// Forward-select codes, the scheduler state enum and the shadow stage tag live here.
package pipeline_pkg;

  // Shadow tags are sized for the 6-bit register space (bit 5 = HI/LO/CP0 extension).
  localparam int TAG_REG_W = 6;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM_ALU = 2'b01;
  localparam logic [1:0] FWD_WB_ALU  = 2'b10;
  localparam logic [1:0] FWD_WB_LOAD = 2'b11;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_REG_W-1:0] wr_reg;
    logic                 is_load;
  } stage_tag_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Combinational tag compare for one ID source operand: the EX-stage forward
// select it will need next cycle, and whether it collides with a load in EX.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int               REG_W    = TAG_REG_W,
  parameter logic [REG_W-1:0] ZERO_REG = '0
) (
  input  logic             id_valid,
  input  logic             src_used,
  input  logic [REG_W-1:0] src,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_reg,
  input  logic             ex_load,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_reg,
  input  logic             mem_load,
  output logic [1:0]       sel,
  output logic             lu_hit
);

  logic live;
  logic ex_hit;
  logic mem_hit;

  assign live    = src_used && (src != ZERO_REG);
  assign ex_hit  = live && ex_valid && (ex_reg == src);
  assign mem_hit = live && mem_valid && (mem_reg == src);
  assign lu_hit  = id_valid && ex_hit && ex_load;

  // EX producer is checked first so the youngest value wins; a WB producer
  // needs nothing because the register file is write-first.
  always_comb begin
    sel = FWD_REGFILE;
    if (ex_hit && !ex_load) begin
      sel = FWD_MEM_ALU;
    end else if (mem_hit) begin
      sel = mem_load ? FWD_WB_LOAD : FWD_WB_ALU;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard scheduler for the 5-stage pipeline: shadow EX/MEM/WB tags,
// registered forward selects, load-use bubbles, branch flush and memory-wait freeze.
// Optional build macro HAZARD_PERF_EN adds saturating event counters and their ports.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int               REG_W    = TAG_REG_W,
  parameter logic [REG_W-1:0] ZERO_REG = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_wait,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [1:0]       dbg_state,
  output logic [2:0]       dbg_shadow_valid,
  output logic [REG_W+1:0] dbg_wb_tag
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_lu_stall,
  output logic [31:0]      perf_flush,
  output logic [31:0]      perf_wait
`endif
);

  stage_tag_t ex_t, mem_t, wb_t;
  hz_state_t  state, state_nxt;
  logic [1:0] sel_a, sel_b;
  logic       lu_a, lu_b, load_use;

  fwd_select #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .id_valid (id_valid),
    .src_used (id_rs_used),
    .src      (id_rs),
    .ex_valid (ex_t.valid),
    .ex_reg   (ex_t.wr_reg),
    .ex_load  (ex_t.is_load),
    .mem_valid(mem_t.valid),
    .mem_reg  (mem_t.wr_reg),
    .mem_load (mem_t.is_load),
    .sel      (sel_a),
    .lu_hit   (lu_a)
  );

  fwd_select #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .id_valid (id_valid),
    .src_used (id_rt_used),
    .src      (id_rt),
    .ex_valid (ex_t.valid),
    .ex_reg   (ex_t.wr_reg),
    .ex_load  (ex_t.is_load),
    .mem_valid(mem_t.valid),
    .mem_reg  (mem_t.wr_reg),
    .mem_load (mem_t.is_load),
    .sel      (sel_b),
    .lu_hit   (lu_b)
  );

  assign load_use = lu_a || lu_b;

  // Priority: rst > mem_wait > taken branch > load-use. A flush already
  // discards the dependent instruction, so it never also stalls.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    state_nxt = RUN;
    if (rst) begin
      state_nxt = RUN;
    end else if (mem_wait) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      state_nxt = state;
    end else if (ex_branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
      state_nxt = FLUSH;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
      state_nxt = LU_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_t      <= '0;
      mem_t     <= '0;
      wb_t      <= '0;
      fwd_sel_a <= FWD_REGFILE;
      fwd_sel_b <= FWD_REGFILE;
      state     <= RUN;
    end else if (!mem_wait) begin
      wb_t  <= mem_t;
      mem_t <= ex_t;
      state <= state_nxt;
      if (bubble_ex) begin
        ex_t      <= '0;
        fwd_sel_a <= FWD_REGFILE;
        fwd_sel_b <= FWD_REGFILE;
      end else begin
        ex_t      <= '{valid: id_valid && id_wr_en, wr_reg: id_wr_reg, is_load: id_is_load};
        fwd_sel_a <= sel_a;
        fwd_sel_b <= sel_b;
      end
    end
  end

  assign dbg_state        = state;
  assign dbg_shadow_valid = {wb_t.valid, mem_t.valid, ex_t.valid};
  assign dbg_wb_tag       = wb_t;

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_stall_cnt, flush_cnt, wait_cnt;
  logic        lu_ev, flush_ev;

  assign lu_ev    = !mem_wait && !ex_branch_taken && load_use;
  assign flush_ev = !mem_wait && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt <= '0;
      flush_cnt    <= '0;
      wait_cnt     <= '0;
    end else begin
      if (lu_ev && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + 32'd1;
      if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
      if (mem_wait && (wait_cnt != '1)) wait_cnt <= wait_cnt + 32'd1;
    end
  end

  assign perf_lu_stall = lu_stall_cnt;
  assign perf_flush    = flush_cnt;
  assign perf_wait     = wait_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl; the reference keeps the
// in-flight instructions as a youngest-first list and applies the hazard rules directly.
module tb_pipeline_hazard_ctrl;

  localparam int W = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic [5:0] id_rs, id_rt, id_wr_reg;
  logic       ex_branch_taken, mem_wait;
  logic       stall_if, stall_id, bubble_ex, flush_id;
  logic [1:0] fwd_sel_a, fwd_sel_b, dbg_state;
  logic [2:0] dbg_shadow_valid;
  logic [7:0] dbg_wb_tag;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_stall, perf_flush, perf_wait;
`endif

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_wait(mem_wait), .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .dbg_state(dbg_state), .dbg_shadow_valid(dbg_shadow_valid), .dbg_wb_tag(dbg_wb_tag)
`ifdef HAZARD_PERF_EN
    , .perf_lu_stall(perf_lu_stall), .perf_flush(perf_flush), .perf_wait(perf_wait)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: in-flight producers, index 0 = instruction now in EX
  typedef struct {
    bit       v;
    bit [5:0] rd;
    bit       ld;
  } rec_t;

  rec_t        pipe[$];
  int          m_state;  // 0 run, 1 load-use stall, 2 flush
  logic [1:0]  m_fa, m_fb;
  int unsigned m_lu, m_fl, m_wt;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    rec_t e;
    e.v = 0; e.rd = 0; e.ld = 0;
    pipe.delete();
    repeat (3) pipe.push_back(e);
    m_state = 0; m_fa = 2'b00; m_fb = 2'b00;
    m_lu = 0; m_fl = 0; m_wt = 0;
  endfunction

  // Youngest producer wins: EX-age ALU -> MEM ALU path, MEM-age -> WB path.
  function automatic logic [1:0] m_fwd(logic used, logic [5:0] src);
    if (!used || src == 6'd0) return 2'b00;
    if (pipe[0].v && pipe[0].rd == src && !pipe[0].ld) return 2'b01;
    if (pipe[1].v && pipe[1].rd == src) return pipe[1].ld ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  // driver: apply one cycle of ID/control inputs, queue expected response, advance model
  task automatic step(input logic r, input logic v, input logic [5:0] rs, input logic ru,
                      input logic [5:0] rt, input logic tu, input logic we,
                      input logic [5:0] wr, input logic ld, input logic br, input logic wt);
    logic lu, si, sd, bx, fi;
    logic [1:0] na, nb;
    rec_t n;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs = rs; id_rs_used = ru; id_rt = rt; id_rt_used = tu;
    id_wr_en = we; id_wr_reg = wr; id_is_load = ld; ex_branch_taken = br; mem_wait = wt;

    lu = v && pipe[0].v && pipe[0].ld &&
         ((ru && rs != 0 && rs == pipe[0].rd) || (tu && rt != 0 && rt == pipe[0].rd));
    {si, sd, bx, fi} = 4'b0000;
    if (r) {si, sd, bx, fi} = 4'b0000;
    else if (wt) {si, sd, bx, fi} = 4'b1100;
    else if (br) {si, sd, bx, fi} = 4'b0011;
    else if (lu) {si, sd, bx, fi} = 4'b1110;
    exp_q.push_back({si, sd, bx, fi, m_fa, m_fb, 2'(m_state),
                     logic'(pipe[2].v), logic'(pipe[1].v), logic'(pipe[0].v)});

    if (r) begin
      model_reset();
    end else if (wt) begin
      m_wt++;
    end else begin
      na = bx ? 2'b00 : m_fwd(ru, rs);
      nb = bx ? 2'b00 : m_fwd(tu, rt);
      n.v = !bx && v && we; n.rd = wr; n.ld = ld;
      pipe.push_front(n);
      void'(pipe.pop_back());
      m_fa = na; m_fb = nb;
      m_state = br ? 2 : (lu ? 1 : 0);
      if (br) m_fl++;
      else if (lu) m_lu++;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] exp, act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {stall_if, stall_id, bubble_ex, flush_id, fwd_sel_a, fwd_sel_b,
               dbg_state, dbg_shadow_valid};
        n_checks++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t actual{sif,sid,bub,fl,fa,fb,st,vld}=%b_%b_%b_%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b_%b_%b_%b",
                   $time, act[12], act[11], act[10], act[9], act[8:7], act[6:5], act[4:3], act[2:0],
                   exp[12], exp[11], exp[10], exp[9], exp[8:7], exp[6:5], exp[4:3], exp[2:0]);
        end
      end
    end
  end

  initial begin
    rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_wr_en = 0; id_wr_reg = 0; id_is_load = 0; ex_branch_taken = 0; mem_wait = 0;
    model_reset();
    repeat (2) @(posedge clk);

    // ALU back-to-back: add $3 then read rs=3
    idle();
    step(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0, 1, 8, 0, 0, 0);
    idle();
    // load-use: lw $5 then rt=5, reissued after the bubble
    step(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    step(0, 1, 1, 1, 5, 1, 1, 6, 0, 0, 0);
    step(0, 1, 1, 1, 5, 1, 1, 6, 0, 0, 0);
    idle();
    // register zero
    step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0);
    idle();
    // branch vs load-use in the same cycle
    step(0, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    step(0, 1, 7, 1, 0, 0, 1, 2, 0, 1, 0);
    idle();
    // mem_wait held 3 cycles inside the load-use stall
    step(0, 1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    step(0, 1, 0, 0, 9, 1, 1, 4, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 9, 1, 1, 4, 0, 0, 1);
    step(0, 1, 0, 0, 9, 1, 1, 4, 0, 0, 0);
    idle();
    // reset while in LU_STALL
    step(0, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    step(0, 1, 4, 1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 1, 4, 1, 0, 0, 1, 1, 0, 0, 0);
    idle();
    idle();

    // randomized traffic with a small register pool to provoke hazards
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8,
           6'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           6'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, 6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10);
    end
    idle();

    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d entries left required=0", exp_q.size());
    end
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (perf_lu_stall !== m_lu) begin
      n_fail++;
      $display("FAIL perf_lu_stall actual=%0d required=%0d", perf_lu_stall, m_lu);
    end
    n_checks++;
    if (perf_flush !== m_fl) begin
      n_fail++;
      $display("FAIL perf_flush actual=%0d required=%0d", perf_flush, m_fl);
    end
    n_checks++;
    if (perf_wait !== m_wt) begin
      n_fail++;
      $display("FAIL perf_wait actual=%0d required=%0d", perf_wait, m_wt);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
